// File: rtl/dff_pkg.sv
// Shared constants, stage-action encoding and width helper for the dff_pipe elastic register pipeline.
package dff_pkg;

  localparam int unsigned DFF_DEFAULT_WIDTH = 8;
  localparam int unsigned DFF_DEFAULT_DEPTH = 3;

  // Narrowed to WIDTH at each use site.
  localparam logic [63:0] DFF_RESET_VAL = '0;

  typedef enum logic [1:0] {
    STG_HOLD,
    STG_LOAD,
    STG_CLEAR,
    STG_FLUSH
  } stg_act_e;

  // Minimum bit width able to index n distinct values; never returns 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: WIDTH-bit data register, valid bit and ready term.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_ready_i,
  output logic             rdy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  stg_act_e         act;

  assign rdy_o   = ~valid_q | dn_ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Flush outranks a load, so a word offered during flush is dropped.
  always_comb begin
    act = STG_HOLD;
    if (flush_i)                  act = STG_FLUSH;
    else if (rdy_o && up_valid_i) act = STG_LOAD;
    else if (rdy_o)               act = STG_CLEAR;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (act)
      STG_LOAD: begin
        valid_d = 1'b1;
        data_d  = up_data_i;
      end
      STG_CLEAR, STG_FLUSH: valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Parametrised elastic register pipeline of DEPTH valid/ready stages.
// Define DFF_PIPE_COUNT_EN to add the o_count occupancy output.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_DEFAULT_WIDTH,
  parameter int unsigned      DEPTH     = DFF_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qb
`ifdef DFF_PIPE_COUNT_EN
  ,
  output logic [clog2(DEPTH+1)-1:0] o_count
`endif
);

  // Index k is the input side of stage k; index DEPTH is the pipe output.
  logic             rdy_w  [DEPTH+1];
  logic             vld_w  [DEPTH+1];
  logic [WIDTH-1:0] data_w [DEPTH+1];

  assign vld_w[0]      = i_valid;
  assign data_w[0]     = i_d;
  assign rdy_w[DEPTH]  = i_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (i_flush),
      .up_valid_i (vld_w[k]),
      .up_data_i  (data_w[k]),
      .dn_ready_i (rdy_w[k+1]),
      .rdy_o      (rdy_w[k]),
      .valid_o    (vld_w[k+1]),
      .data_o     (data_w[k+1])
    );
  end

  assign o_ready = rdy_w[0];
  assign o_valid = vld_w[DEPTH];
  assign o_q     = data_w[DEPTH];
  assign o_qb    = ~data_w[DEPTH];

`ifdef DFF_PIPE_COUNT_EN
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic          xfer_in, xfer_out;

  assign xfer_in  = i_valid & o_ready;
  assign xfer_out = o_valid & i_ready;

  // Internal stage-to-stage moves never change occupancy; only the pipe ends do.
  always_comb begin
    count_d = count_q;
    if (i_flush)                  count_d = '0;
    else if (xfer_in && !xfer_out) count_d = count_q + CW'(1);
    else if (!xfer_in && xfer_out) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_count = count_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VAL=A5) with a queue scoreboard.
module tb_dff_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam logic [7:0]  RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] i_d = '0;
  logic       o_ready, o_valid;
  logic [7:0] o_q, o_qb;
`ifdef DFF_PIPE_COUNT_EN
  logic [1:0] o_count;
`endif

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH     (W),
    .DEPTH     (D),
    .RESET_VAL (RV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_d     (i_d),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_q     (o_q),
    .o_qb    (o_qb)
`ifdef DFF_PIPE_COUNT_EN
    ,
    .o_count (o_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  logic       s_acc, s_out, s_ordy, s_ovalid;
  logic [7:0] s_q, exp_q;
  logic [1:0] s_cnt;

  // Drive one cycle's inputs away from the edge, sample the pre-edge state, then take the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
    @(negedge clk);
    i_valid = v; i_d = d; i_ready = rdy; i_flush = fl;
    #1;
    s_ordy   = o_ready;
    s_ovalid = o_valid;
    s_q      = o_q;
    s_acc    = v & o_ready;
    s_out    = o_valid & rdy;
`ifdef DFF_PIPE_COUNT_EN
    s_cnt    = o_count;
`else
    s_cnt    = '0;
`endif
    @(posedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_q !== RV || o_qb !== ~RV || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: valid=%b q=%h qb=%h rdy=%b, want 0 %h %h 1", o_valid, o_q, o_qb, o_ready, RV, ~RV);
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_q !== RV || o_qb !== 8'h5A || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b q=%h qb=%h rdy=%b, want 0 a5 5a 1", o_valid, o_q, o_qb, o_ready);
    end
`ifdef DFF_PIPE_COUNT_EN
    checks++;
    if (o_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", o_count);
    end
`endif
    @(negedge clk) reset = 1'b0;
    i_valid = 1'b0;
    sb.delete();
  endtask

  task automatic test_stream;
    int outs = 0;
    for (int c = 0; c < 9; c++) begin
      step(c < 3, 8'(c + 1), 1'b1, 1'b0);
      if (c < 3) begin
        checks++;
        if (s_ordy !== 1'b1 || s_ovalid !== 1'b0) begin
          errors++;
          $display("FAIL stream_fill c%0d: rdy=%b valid=%b, want 1 0", c, s_ordy, s_ovalid);
        end
      end
      if (s_out) begin
        exp_q = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (s_q !== exp_q || c != outs + 3) begin
          errors++;
          $display("FAIL stream_out c%0d: got %h want %h at cycle %0d", c, s_q, exp_q, outs + 3);
        end
        outs++;
      end
      if (s_acc) sb.push_back(i_d);
    end
    checks++;
    if (outs != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d words (%0d left), want 3 (0 left)", outs, sb.size());
    end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 8'(c + 1), 1'b0, 1'b0);
      if (s_acc) begin
        sb.push_back(i_d);
        acc++;
      end
      if (c == 3) begin
        checks++;
        if (s_ordy !== 1'b0 || s_ovalid !== 1'b1 || s_q !== 8'h01) begin
          errors++;
          $display("FAIL bp_full: rdy=%b valid=%b q=%h, want 0 1 01", s_ordy, s_ovalid, s_q);
        end
      end
    end
    checks++;
    if (acc != 3) begin
      errors++;
      $display("FAIL bp_accepted: got %0d want 3", acc);
    end
  endtask

  task automatic test_back_to_back;
    int outs = 0;
    step(1'b1, 8'h04, 1'b1, 1'b0);
    checks++;
    if (s_ordy !== 1'b1 || s_out !== 1'b1 || s_acc !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hs: rdy=%b out=%b in=%b, want 1 1 1", s_ordy, s_out, s_acc);
    end
`ifdef DFF_PIPE_COUNT_EN
    checks++;
    if (s_cnt !== 2'd3) begin
      errors++;
      $display("FAIL b2b_count_before: got %0d want 3", s_cnt);
    end
`endif
    if (s_out) begin
      exp_q = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      checks++;
      if (s_q !== exp_q) begin
        errors++;
        $display("FAIL b2b_out: got %h want %h", s_q, exp_q);
      end
    end
    if (s_acc) sb.push_back(8'h04);
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef DFF_PIPE_COUNT_EN
      if (c == 0) begin
        checks++;
        if (s_cnt !== 2'd3) begin
          errors++;
          $display("FAIL b2b_count_after: got %0d want 3", s_cnt);
        end
      end
`endif
      if (s_out) begin
        exp_q = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (s_q !== exp_q) begin
          errors++;
          $display("FAIL drain_out: got %h want %h", s_q, exp_q);
        end
        outs++;
      end
    end
    checks++;
    if (outs != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_count: got %0d words (%0d left), want 3 (0 left)", outs, sb.size());
    end
  endtask

  task automatic test_flush;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 8'(8'h11 + c), 1'b0, 1'b0);
      if (s_acc) sb.push_back(i_d);
    end
    step(1'b1, 8'h09, 1'b1, 1'b1);
    checks++;
    if (s_out !== 1'b1 || s_q !== 8'h11) begin
      errors++;
      $display("FAIL flush_edge_out: out=%b q=%h, want 1 11", s_out, s_q);
    end
    sb.delete();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (s_ovalid !== 1'b0 || s_q !== 8'h11 || s_cnt !== 2'd0) begin
        errors++;
        $display("FAIL flush_after c%0d: valid=%b q=%h count=%0d, want 0 11 0", c, s_ovalid, s_q, s_cnt);
      end
    end
  endtask

  task automatic test_toggle_ready;
    int outs = 0;
    for (int c = 0; c < 14; c++) begin
      step(c == 0 || c == 2, (c == 0) ? 8'h7E : 8'h7F, 1'(c % 2), 1'b0);
      if (s_out) begin
        exp_q = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (s_q !== exp_q) begin
          errors++;
          $display("FAIL toggle_out c%0d: got %h want %h", c, s_q, exp_q);
        end
        outs++;
      end
      if (s_acc) sb.push_back(i_d);
    end
    checks++;
    if (outs != 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL toggle_count: got %0d words (%0d left), want 2 (0 left)", outs, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_toggle_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
